// File: rtl/myio_pkg.sv
// rtl/myio_pkg.sv - shared word offsets, FSM states and helpers for the myIO register bank
package myio_pkg;

    localparam logic [2:0] OFS_GP0     = 3'd0;
    localparam logic [2:0] OFS_GP1     = 3'd1;
    localparam logic [2:0] OFS_GP2     = 3'd2;
    localparam logic [2:0] OFS_GP3     = 3'd3;
    localparam logic [2:0] OFS_GPIN    = 3'd4;
    localparam logic [2:0] OFS_STATUS  = 3'd5;
    localparam logic [2:0] OFS_IRQ_EN  = 3'd6;
    localparam logic [2:0] OFS_VERSION = 3'd7;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/myio_input_sync.sv
// rtl/myio_input_sync.sv - 2-FF synchroniser for async switch inputs plus rising-edge pulse
module myio_input_sync #(
    parameter int GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_sync,
    output logic [GPIO_WIDTH-1:0] gpio_rise
);

    logic [GPIO_WIDTH-1:0] meta_q;
    logic [GPIO_WIDTH-1:0] sync_q;
    logic [GPIO_WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= gpio_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign gpio_sync = sync_q;
    assign gpio_rise = sync_q & ~prev_q;

endmodule

// File: rtl/myio_axil_gpio_regs.sv
// rtl/myio_axil_gpio_regs.sv - AXI4-Lite register bank: 4 RW words, synced GPIO, W1C edge status, irq
module myio_axil_gpio_regs
    import myio_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter int          GPIO_WIDTH         = 8,
    parameter logic [31:0] VERSION            = 32'h0001_0000
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    input  logic [GPIO_WIDTH-1:0]             gpio_in,
    output logic [GPIO_WIDTH-1:0]             gpio_out,
    output logic                              irq
);

    logic                  clk;
    logic                  rst_n;
    logic                  active;
    wr_state_t             wr_state, wr_state_n;
    rd_state_t             rd_state, rd_state_n;
    logic                  aw_full, w_full;
    logic [2:0]            aw_word_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, do_write;
    logic [2:0]            wr_word;
    logic [31:0]           wr_data, wr_mask, wr_merged, clr_full;
    logic [3:0]            wr_strb;
    logic [31:0]           gp [4];
    logic [31:0]           words [8];
    logic [GPIO_WIDTH-1:0] gpio_sync, gpio_rise, status, status_n, status_clr, irq_en;
    logic                  unused_inputs;

    assign clk           = s00_axi_aclk;
    assign rst_n         = s00_axi_aresetn;
    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    myio_input_sync #(.GPIO_WIDTH(GPIO_WIDTH)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .gpio_in   (gpio_in),
        .gpio_sync (gpio_sync),
        .gpio_rise (gpio_rise)
    );

    // Ready outputs stay low while reset is held and for the first cycle after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) active <= 1'b0;
        else        active <= 1'b1;
    end

    assign s00_axi_awready = active & (wr_state == W_IDLE) & ~aw_full;
    assign s00_axi_wready  = active & (wr_state == W_IDLE) & ~w_full;
    assign s00_axi_bvalid  = (wr_state == W_RESP);
    assign s00_axi_bresp   = RESP_OKAY;
    assign s00_axi_arready = active & (rd_state == R_IDLE);
    assign s00_axi_rvalid  = (rd_state == R_DATA);
    assign s00_axi_rresp   = RESP_OKAY;

    assign aw_hs    = s00_axi_awvalid & s00_axi_awready;
    assign w_hs     = s00_axi_wvalid & s00_axi_wready;
    assign b_hs     = s00_axi_bvalid & s00_axi_bready;
    assign ar_hs    = s00_axi_arvalid & s00_axi_arready;
    assign r_hs     = s00_axi_rvalid & s00_axi_rready;
    assign do_write = (wr_state == W_IDLE) & (aw_full | aw_hs) & (w_full | w_hs);

    // A latched slot takes priority; otherwise the beat arriving this cycle is used directly.
    assign wr_word = aw_full ? aw_word_q : s00_axi_awaddr[4:2];
    assign wr_data = w_full ? wdata_q : s00_axi_wdata;
    assign wr_strb = w_full ? wstrb_q : s00_axi_wstrb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_state_n;
            rd_state <= rd_state_n;
        end
    end

    always_comb begin
        wr_state_n = wr_state;
        rd_state_n = rd_state;
        case (wr_state)
            W_IDLE:  if (do_write) wr_state_n = W_RESP;
            W_RESP:  if (b_hs)     wr_state_n = W_IDLE;
            default: wr_state_n = W_IDLE;
        endcase
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_state_n = R_DATA;
            R_DATA:  if (r_hs)  rd_state_n = R_IDLE;
            default: rd_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_word_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else if (b_hs) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_word_q <= s00_axi_awaddr[4:2];
            end
            if (w_hs) begin
                w_full  <= 1'b1;
                wdata_q <= s00_axi_wdata;
                wstrb_q <= s00_axi_wstrb;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) words[i] = '0;
        for (int i = 0; i < 4; i++) words[i] = gp[i];
        words[OFS_GPIN][GPIO_WIDTH-1:0]   = gpio_sync;
        words[OFS_STATUS][GPIO_WIDTH-1:0] = status;
        words[OFS_IRQ_EN][GPIO_WIDTH-1:0] = irq_en;
        words[OFS_VERSION]                = VERSION;
    end

    assign wr_mask   = strb_mask(wr_strb);
    assign wr_merged = (words[wr_word] & ~wr_mask) | (wr_data & wr_mask);
    assign clr_full  = wr_data & wr_mask;

    // A rising edge arriving in the same cycle as its W1C clear wins.
    always_comb begin
        status_clr = '0;
        if (do_write && wr_word == OFS_STATUS) status_clr = clr_full[GPIO_WIDTH-1:0];
        status_n = (status & ~status_clr) | gpio_rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) gp[i] <= '0;
            irq_en        <= '0;
            status        <= '0;
            irq           <= 1'b0;
            s00_axi_rdata <= '0;
        end else begin
            if (do_write && wr_word <= OFS_GP3) gp[wr_word[1:0]] <= wr_merged;
            if (do_write && wr_word == OFS_IRQ_EN) irq_en <= wr_merged[GPIO_WIDTH-1:0];
            status <= status_n;
            irq    <= |(status & irq_en);
            if (ar_hs) s00_axi_rdata <= words[s00_axi_araddr[4:2]];
        end
    end

    assign gpio_out = gp[OFS_GP0[1:0]][GPIO_WIDTH-1:0];

endmodule

// File: tb/tb_myio_axil_gpio_regs.sv
// tb/tb_myio_axil_gpio_regs.sv - directed self-checking bench for myio_axil_gpio_regs
module tb_myio_axil_gpio_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [7:0]  gpio_in, gpio_out;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_val;

    always #5 clk = ~clk;

    myio_axil_gpio_regs dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .gpio_in         (gpio_in),
        .gpio_out        (gpio_out),
        .irq             (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic aw_hs, w_hs;
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            n++;
        end
        check("wr_accept_timeout", {30'd0, awvalid, wvalid}, 32'd0);
        check("wr_bvalid", {31'd0, bvalid}, 32'd1);
        check("wr_bresp", {30'd0, bresp}, 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        check("rd_arready_timeout", {31'd0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        check("rd_latency", {31'd0, rvalid}, 32'd1);
        check("rd_rresp", {30'd0, rresp}, 32'd0);
        d = rdata;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0;
        wdata = '0; wstrb = '0; gpio_in = 8'h00;
        repeat (3) tick();

        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: plain RW words
        for (int i = 0; i < 4; i++) axi_write(5'(4 * i), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i), rd_val);
            check("t1_readback", rd_val, 32'(i + 1));
        end
        check("t1_gpio_out", {24'd0, gpio_out}, 32'h01);

        // 2: byte strobes
        axi_write(5'h00, 32'h0, 4'hF);
        axi_write(5'h00, 32'hAABBCCDD, 4'b0010);
        axi_read(5'h00, rd_val);
        check("t2_wstrb", rd_val, 32'h0000CC00);

        // 3: W three cycles ahead of AW, response held under bready low
        wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        tick();
        wvalid = 1'b0;
        check("t3_wready_full", {31'd0, wready}, 32'd0);
        tick();
        tick();
        check("t3_no_early_b", {31'd0, bvalid}, 32'd0);
        awaddr = 5'h08; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("t3_bvalid", {31'd0, bvalid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_bvalid_held", {31'd0, bvalid}, 32'd1);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("t3_bvalid_drop", {31'd0, bvalid}, 32'd0);
        axi_read(5'h08, rd_val);
        check("t3_data", rd_val, 32'h55);

        // 4: gpio sync, edge status, irq, W1C
        axi_write(5'h18, 32'h01, 4'hF);
        check("t4_irq_idle", {31'd0, irq}, 32'd0);
        gpio_in = 8'h05;
        repeat (3) tick();
        axi_read(5'h14, rd_val);
        check("t4_status", rd_val, 32'h05);
        axi_read(5'h10, rd_val);
        check("t4_gpin", rd_val, 32'h05);
        check("t4_irq_set", {31'd0, irq}, 32'd1);
        axi_write(5'h14, 32'h01, 4'hF);
        check("t4_irq_clr", {31'd0, irq}, 32'd0);
        axi_read(5'h14, rd_val);
        check("t4_status_w1c", rd_val, 32'h04);

        // 5: version is read-only
        axi_read(5'h1C, rd_val);
        check("t5_version", rd_val, 32'h00010000);
        axi_write(5'h1C, 32'hFFFFFFFF, 4'hF);
        axi_read(5'h1C, rd_val);
        check("t5_version_ro", rd_val, 32'h00010000);

        // 6: reset with a response pending
        axi_write(5'h04, 32'h12345678, 4'hF);
        awaddr = 5'h00; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t6_bvalid_pending", {31'd0, bvalid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_bvalid_async", {31'd0, bvalid}, 32'd0);
        check("t6_gpio_out", {24'd0, gpio_out}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("t6_no_response", {31'd0, bvalid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i), rd_val);
            check("t6_word_cleared", rd_val, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
